// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: latch control,
// forwarding selects, controller state and the priority rule in force.
package hazard_fwd_unit_pkg;

   typedef enum logic [1:0] {
      PIPE_ENABLE = 2'd0,
      PIPE_STALL  = 2'd1,
      PIPE_NOP    = 2'd2
   } pipe_state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LUSTALL = 2'd1,
      DWAIT   = 2'd2
   } hu_state_t;

   // Highest-priority condition active this cycle; drives both outputs and FSM.
   typedef enum logic [2:0] {
      R_RESET  = 3'd0,
      R_DWAIT  = 3'd1,
      R_IWAIT  = 3'd2,
      R_FLUSH  = 3'd3,
      R_HAZARD = 3'd4,
      R_RUN    = 3'd5
   } hu_rule_t;

   localparam int unsigned LU_CNT_W = 3;

   typedef struct packed {
      logic        pc_wen;
      pipe_state_t fd;
      pipe_state_t de;
      pipe_state_t em;
      pipe_state_t mw;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_RESET  = '{pc_wen: 1'b0, fd: PIPE_NOP,    de: PIPE_NOP,    em: PIPE_NOP,    mw: PIPE_NOP};
   localparam pipe_ctl_t CTL_DWAIT  = '{pc_wen: 1'b0, fd: PIPE_STALL,  de: PIPE_STALL,  em: PIPE_STALL,  mw: PIPE_NOP};
   localparam pipe_ctl_t CTL_IWAIT  = '{pc_wen: 1'b0, fd: PIPE_STALL,  de: PIPE_STALL,  em: PIPE_NOP,    mw: PIPE_ENABLE};
   localparam pipe_ctl_t CTL_FLUSH  = '{pc_wen: 1'b1, fd: PIPE_NOP,    de: PIPE_NOP,    em: PIPE_ENABLE, mw: PIPE_ENABLE};
   localparam pipe_ctl_t CTL_HAZARD = '{pc_wen: 1'b0, fd: PIPE_STALL,  de: PIPE_NOP,    em: PIPE_ENABLE, mw: PIPE_ENABLE};
   localparam pipe_ctl_t CTL_RUN    = '{pc_wen: 1'b1, fd: PIPE_ENABLE, de: PIPE_ENABLE, em: PIPE_ENABLE, mw: PIPE_ENABLE};

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Datapath <-> hazard unit signal bundle; the datapath is master, the
// hazard unit is slave.
interface hazard_fwd_unit_if
   import hazard_fwd_unit_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
);
   logic              ihit, dhit, dmem_req;
   logic [REG_AW-1:0] rs, rt, ex_rs, ex_rt;
   logic [REG_AW-1:0] ex_wsel, mem_wsel, wb_wsel;
   logic              ex_wen, mem_wen, wb_wen;
   logic              ex_memread, branch_taken, perf_clr;

   logic              pc_wen;
   pipe_state_t       fd_state, de_state, em_state, mw_state;
   fwd_t              fwd_a, fwd_b;
   logic              mem_wait;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   modport master (
      output ihit, dhit, dmem_req, rs, rt, ex_rs, ex_rt,
             ex_wsel, mem_wsel, wb_wsel, ex_wen, mem_wen, wb_wen,
             ex_memread, branch_taken, perf_clr,
      input  pc_wen, fd_state, de_state, em_state, mw_state,
             fwd_a, fwd_b, mem_wait, stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dhit, dmem_req, rs, rt, ex_rs, ex_rt,
             ex_wsel, mem_wsel, wb_wsel, ex_wen, mem_wen, wb_wen,
             ex_memread, branch_taken, perf_clr,
      output pc_wen, fd_state, de_state, em_state, mw_state,
             fwd_a, fwd_b, mem_wait, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_fwd_unit_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module hazard_fwd_unit_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/hazard_fwd_unit.sv
// Five-stage pipeline hazard controller: latch control, PC enable, EX operand
// forwarding, load-use / memory-wait FSM and stall/flush counters.
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter bit          FORWARD_EN = 1'b1,
   parameter int unsigned LU_STALL   = 1,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned CNT_W      = 16
) (
   input logic         CLK,
   input logic         nRST,
   hazard_fwd_unit_if.slave hif
);
   hu_state_t           state_q, state_d;
   logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
   logic                mem_wait_q, mem_wait_d;
   hu_rule_t            rule;
   pipe_ctl_t           ctl;
   fwd_t                fwd_a, fwd_b;
   logic                lu_hit, hazard;
   logic [CNT_W-1:0]    stall_cnt, flush_cnt;

   function automatic logic reg_match(input logic [REG_AW-1:0] wsel, input logic wen,
                                      input logic [REG_AW-1:0] src);
      return wen && (wsel != '0) && (wsel == src);
   endfunction

   function automatic fwd_t fwd_sel(input logic [REG_AW-1:0] src,
                                    input logic [REG_AW-1:0] mem_wsel, input logic mem_wen,
                                    input logic [REG_AW-1:0] wb_wsel, input logic wb_wen);
      if (reg_match(mem_wsel, mem_wen, src))
         return FWD_MEM;
      else if (reg_match(wb_wsel, wb_wen, src))
         return FWD_WB;
      return FWD_RF;
   endfunction

   always_comb begin
      lu_hit = hif.ex_memread &
               (reg_match(hif.ex_wsel, hif.ex_wen, hif.rs) | reg_match(hif.ex_wsel, hif.ex_wen, hif.rt));
      if (FORWARD_EN)
         hazard = (state_q == LUSTALL) | lu_hit;
      else
         hazard = reg_match(hif.ex_wsel, hif.ex_wen, hif.rs)   | reg_match(hif.ex_wsel, hif.ex_wen, hif.rt) |
                  reg_match(hif.mem_wsel, hif.mem_wen, hif.rs) | reg_match(hif.mem_wsel, hif.mem_wen, hif.rt);

      if (!nRST)                           rule = R_RESET;
      else if (hif.dmem_req && !hif.dhit)  rule = R_DWAIT;
      else if (!hif.ihit)                  rule = R_IWAIT;
      else if (hif.branch_taken)           rule = R_FLUSH;
      else if (hazard)                     rule = R_HAZARD;
      else                                 rule = R_RUN;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q    <= RUN;
         lu_cnt_q   <= '0;
         mem_wait_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lu_cnt_q   <= lu_cnt_d;
         mem_wait_q <= mem_wait_d;
      end
   end

   // The first load-use stall cycle is spent in RUN, so LUSTALL covers the rest.
   always_comb begin
      state_d  = state_q;
      lu_cnt_d = lu_cnt_q;
      case (state_q)
         RUN: begin
            if (rule == R_DWAIT)
               state_d = DWAIT;
            else if (FORWARD_EN && (rule == R_HAZARD) && (LU_STALL > 1)) begin
               state_d  = LUSTALL;
               lu_cnt_d = LU_CNT_W'(LU_STALL - 1);
            end
         end
         LUSTALL: begin
            if (rule == R_DWAIT)
               state_d = DWAIT;
            else if (rule == R_FLUSH) begin
               state_d  = RUN;
               lu_cnt_d = '0;
            end else if (rule == R_HAZARD) begin
               lu_cnt_d = lu_cnt_q - 1'b1;
               if (lu_cnt_q <= LU_CNT_W'(1))
                  state_d = RUN;
            end
         end
         DWAIT: begin
            if (rule != R_DWAIT)
               state_d = (lu_cnt_q != '0) ? LUSTALL : RUN;
         end
         default: begin
            state_d  = RUN;
            lu_cnt_d = '0;
         end
      endcase
      mem_wait_d = (state_d == DWAIT);
   end

   always_comb begin
      case (rule)
         R_RESET:  ctl = CTL_RESET;
         R_DWAIT:  ctl = CTL_DWAIT;
         R_IWAIT:  ctl = CTL_IWAIT;
         R_FLUSH:  ctl = CTL_FLUSH;
         R_HAZARD: ctl = CTL_HAZARD;
         default:  ctl = CTL_RUN;
      endcase

      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (FORWARD_EN && nRST) begin
         fwd_a = fwd_sel(hif.ex_rs, hif.mem_wsel, hif.mem_wen, hif.wb_wsel, hif.wb_wen);
         fwd_b = fwd_sel(hif.ex_rt, hif.mem_wsel, hif.mem_wen, hif.wb_wsel, hif.wb_wen);
      end
   end

   hazard_fwd_unit_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (CLK),
      .rst_n (nRST),
      .clr   (hif.perf_clr),
      .inc   (nRST & ~ctl.pc_wen),
      .cnt   (stall_cnt)
   );

   hazard_fwd_unit_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (CLK),
      .rst_n (nRST),
      .clr   (hif.perf_clr),
      .inc   (rule == R_FLUSH),
      .cnt   (flush_cnt)
   );

   assign hif.pc_wen    = ctl.pc_wen;
   assign hif.fd_state  = ctl.fd;
   assign hif.de_state  = ctl.de;
   assign hif.em_state  = ctl.em;
   assign hif.mw_state  = ctl.mw;
   assign hif.fwd_a     = fwd_a;
   assign hif.fwd_b     = fwd_b;
   assign hif.mem_wait  = mem_wait_q;
   assign hif.stall_cnt = stall_cnt;
   assign hif.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench: a forwarding build (LU_STALL=2, 4-bit counters) and a
// stall-only build driven with identical inputs.
module tb_hazard_fwd_unit;
   import hazard_fwd_unit_pkg::*;

   localparam int unsigned AW = 5;
   localparam int unsigned CW = 4;
   localparam int unsigned CMAX = 15;

   typedef struct packed {
      logic ihit, dhit, dmem_req;
      logic [AW-1:0] rs, rt, ex_rs, ex_rt, ex_wsel, mem_wsel, wb_wsel;
      logic ex_wen, mem_wen, wb_wen, ex_memread, branch_taken, perf_clr;
   } in_t;

   typedef struct packed {
      logic pc_wen;
      pipe_state_t fd, de, em, mw;
      fwd_t fa, fb;
   } ctl_t;

   typedef struct packed {
      ctl_t c;
      logic mem_wait;
      logic [CW-1:0] stall, flush;
   } exp_t;

   localparam ctl_t C_RST = '{1'b0, PIPE_NOP,    PIPE_NOP,    PIPE_NOP,    PIPE_NOP,    FWD_RF, FWD_RF};
   localparam ctl_t C_RUN = '{1'b1, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, FWD_RF, FWD_RF};
   localparam ctl_t C_DW  = '{1'b0, PIPE_STALL,  PIPE_STALL,  PIPE_STALL,  PIPE_NOP,    FWD_RF, FWD_RF};
   localparam ctl_t C_IW  = '{1'b0, PIPE_STALL,  PIPE_STALL,  PIPE_NOP,    PIPE_ENABLE, FWD_RF, FWD_RF};
   localparam ctl_t C_FL  = '{1'b1, PIPE_NOP,    PIPE_NOP,    PIPE_ENABLE, PIPE_ENABLE, FWD_RF, FWD_RF};
   localparam ctl_t C_HZ  = '{1'b0, PIPE_STALL,  PIPE_NOP,    PIPE_ENABLE, PIPE_ENABLE, FWD_RF, FWD_RF};

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   hazard_fwd_unit_if #(.REG_AW(AW), .CNT_W(CW)) ifa ();
   hazard_fwd_unit_if #(.REG_AW(AW), .CNT_W(16)) ifb ();

   hazard_fwd_unit #(.FORWARD_EN(1'b1), .LU_STALL(2), .REG_AW(AW), .CNT_W(CW)) u_fwd (
      .CLK(clk), .nRST(nrst), .hif(ifa));
   hazard_fwd_unit #(.FORWARD_EN(1'b0), .LU_STALL(1), .REG_AW(AW), .CNT_W(16)) u_stall (
      .CLK(clk), .nRST(nrst), .hif(ifb));

   exp_t sb_a[$];
   ctl_t sb_b[$];
   int   n_vec = 0;
   int   n_err = 0;

   int unsigned m_stall = 0, m_flush = 0;
   logic last_rst = 1'b0, last_clr = 1'b0, last_pc = 1'b1, last_fl = 1'b0;

   function automatic in_t idle();
      in_t v;
      v = '0;
      v.ihit = 1'b1;
      return v;
   endfunction

   function automatic in_t load_use();
      in_t v;
      v = idle();
      v.ex_memread = 1'b1;
      v.ex_wen = 1'b1;
      v.ex_wsel = 5'd8;
      v.rs = 5'd8;
      return v;
   endfunction

   function automatic ctl_t wf(input ctl_t c, input fwd_t a, input fwd_t b);
      c.fa = a;
      c.fb = b;
      return c;
   endfunction

   function automatic exp_t obs_a();
      exp_t g;
      g.c = '{ifa.pc_wen, ifa.fd_state, ifa.de_state, ifa.em_state, ifa.mw_state, ifa.fwd_a, ifa.fwd_b};
      g.mem_wait = ifa.mem_wait;
      g.stall = ifa.stall_cnt;
      g.flush = ifa.flush_cnt;
      return g;
   endfunction

   function automatic ctl_t obs_b();
      return '{ifb.pc_wen, ifb.fd_state, ifb.de_state, ifb.em_state, ifb.mw_state, ifb.fwd_a, ifb.fwd_b};
   endfunction

   // Applies one cycle of stimulus after the edge, queues expectations, and
   // returns at the following falling edge where outputs are sampled.
   task automatic drive(input in_t v, input logic rst, input ctl_t ea, input logic mw,
                        input ctl_t eb, input logic chk_b);
      exp_t e;
      @(posedge clk);
      #1;
      if (!last_rst) begin
         m_stall = 0;
         m_flush = 0;
      end else if (last_clr) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (!last_pc && m_stall < CMAX) m_stall++;
         if (last_fl && m_flush < CMAX) m_flush++;
      end
      nrst = rst;
      ifa.ihit = v.ihit;           ifb.ihit = v.ihit;
      ifa.dhit = v.dhit;           ifb.dhit = v.dhit;
      ifa.dmem_req = v.dmem_req;   ifb.dmem_req = v.dmem_req;
      ifa.rs = v.rs;               ifb.rs = v.rs;
      ifa.rt = v.rt;               ifb.rt = v.rt;
      ifa.ex_rs = v.ex_rs;         ifb.ex_rs = v.ex_rs;
      ifa.ex_rt = v.ex_rt;         ifb.ex_rt = v.ex_rt;
      ifa.ex_wsel = v.ex_wsel;     ifb.ex_wsel = v.ex_wsel;
      ifa.mem_wsel = v.mem_wsel;   ifb.mem_wsel = v.mem_wsel;
      ifa.wb_wsel = v.wb_wsel;     ifb.wb_wsel = v.wb_wsel;
      ifa.ex_wen = v.ex_wen;       ifb.ex_wen = v.ex_wen;
      ifa.mem_wen = v.mem_wen;     ifb.mem_wen = v.mem_wen;
      ifa.wb_wen = v.wb_wen;       ifb.wb_wen = v.wb_wen;
      ifa.ex_memread = v.ex_memread;     ifb.ex_memread = v.ex_memread;
      ifa.branch_taken = v.branch_taken; ifb.branch_taken = v.branch_taken;
      ifa.perf_clr = v.perf_clr;   ifb.perf_clr = v.perf_clr;
      e.c = ea;
      e.mem_wait = mw;
      e.stall = CW'(m_stall);
      e.flush = CW'(m_flush);
      sb_a.push_back(e);
      if (chk_b) sb_b.push_back(eb);
      last_rst = rst;
      last_clr = v.perf_clr;
      last_pc = ea.pc_wen;
      last_fl = ea.pc_wen && (ea.fd == PIPE_NOP);
      @(negedge clk);
   endtask

   task automatic test_reset();
      exp_t e, g;
      for (int i = 0; i < 4; i++) begin
         drive(idle(), (i == 3), (i == 3) ? C_RUN : C_RST, 1'b0, C_RUN, 1'b0);
         e = sb_a.pop_front();
         g = obs_a();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL reset cyc%0d: got %h expected %h", i, g, e);
         end
      end
   endtask

   task automatic test_load_use();
      in_t  vin[5];
      ctl_t vc[5];
      exp_t e, g;
      vin[0] = load_use();  vc[0] = C_HZ;
      vin[1] = idle();      vc[1] = C_HZ;
      vin[2] = idle();      vc[2] = C_RUN;
      vin[3] = load_use();  vin[3].rs = 5'd0;  vc[3] = C_RUN;
      vin[4] = load_use();  vin[4].rs = 5'd0;  vin[4].rt = 5'd8;  vin[4].ex_wen = 1'b0;  vc[4] = C_RUN;
      for (int i = 0; i < 5; i++) begin
         drive(vin[i], 1'b1, vc[i], 1'b0, C_RUN, 1'b0);
         e = sb_a.pop_front();
         g = obs_a();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL load_use cyc%0d: got %h expected %h", i, g, e);
         end
      end
   endtask

   task automatic test_lu_extend();
      in_t  vin[4];
      ctl_t vc[4];
      exp_t e, g;
      vin[0] = load_use();  vc[0] = C_HZ;
      vin[1] = idle();      vin[1].ihit = 1'b0;  vc[1] = C_IW;
      vin[2] = idle();      vc[2] = C_HZ;
      vin[3] = idle();      vc[3] = C_RUN;
      for (int i = 0; i < 4; i++) begin
         drive(vin[i], 1'b1, vc[i], 1'b0, C_RUN, 1'b0);
         e = sb_a.pop_front();
         g = obs_a();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL lu_extend cyc%0d: got %h expected %h", i, g, e);
         end
      end
   endtask

   task automatic test_forward();
      in_t  vin[5];
      ctl_t va[5];
      exp_t e, g;
      ctl_t eb, gb;
      vin[0] = idle(); vin[0].ex_rs = 5'd3; vin[0].mem_wsel = 5'd3; vin[0].wb_wsel = 5'd3;
      vin[0].mem_wen = 1'b1; vin[0].wb_wen = 1'b1;            va[0] = wf(C_RUN, FWD_MEM, FWD_RF);
      vin[1] = vin[0]; vin[1].mem_wen = 1'b0;                 va[1] = wf(C_RUN, FWD_WB, FWD_RF);
      vin[2] = idle(); vin[2].ex_rt = 5'd3; vin[2].mem_wsel = 5'd5; vin[2].wb_wsel = 5'd3;
      vin[2].mem_wen = 1'b1; vin[2].wb_wen = 1'b1;            va[2] = wf(C_RUN, FWD_RF, FWD_WB);
      vin[3] = idle(); vin[3].mem_wen = 1'b1; vin[3].wb_wen = 1'b1;  va[3] = C_RUN;
      vin[4] = idle(); vin[4].ex_rs = 5'd7; vin[4].ex_rt = 5'd7; vin[4].mem_wsel = 5'd7;
      vin[4].mem_wen = 1'b1;                                  va[4] = wf(C_RUN, FWD_MEM, FWD_MEM);
      for (int i = 0; i < 5; i++) begin
         drive(vin[i], 1'b1, va[i], 1'b0, C_RUN, 1'b1);
         e = sb_a.pop_front();
         g = obs_a();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL forward cyc%0d: got %h expected %h", i, g, e);
         end
         eb = sb_b.pop_front();
         gb = obs_b();
         n_vec++;
         if (gb !== eb) begin
            n_err++;
            $display("FAIL forward_off cyc%0d: got %h expected %h", i, gb, eb);
         end
      end
   endtask

   task automatic test_stall_only();
      in_t  vin[3];
      ctl_t vb[3];
      exp_t e, g;
      ctl_t eb, gb;
      vin[0] = idle(); vin[0].ex_wen = 1'b1; vin[0].ex_wsel = 5'd9; vin[0].rt = 5'd9;   vb[0] = C_HZ;
      vin[1] = idle(); vin[1].mem_wen = 1'b1; vin[1].mem_wsel = 5'd4; vin[1].rs = 5'd4; vb[1] = C_HZ;
      vin[2] = idle(); vin[2].ex_wen = 1'b1;                                            vb[2] = C_RUN;
      for (int i = 0; i < 3; i++) begin
         drive(vin[i], 1'b1, C_RUN, 1'b0, vb[i], 1'b1);
         e = sb_a.pop_front();
         g = obs_a();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL stall_only_fwdbuild cyc%0d: got %h expected %h", i, g, e);
         end
         eb = sb_b.pop_front();
         gb = obs_b();
         n_vec++;
         if (gb !== eb) begin
            n_err++;
            $display("FAIL stall_only cyc%0d: got %h expected %h", i, gb, eb);
         end
      end
   endtask

   task automatic test_mem_wait();
      in_t  vin[5];
      ctl_t vc[5];
      logic vm[5];
      exp_t e, g;
      for (int i = 0; i < 3; i++) begin
         vin[i] = idle(); vin[i].dmem_req = 1'b1; vc[i] = C_DW; vm[i] = (i != 0);
      end
      vin[3] = idle(); vin[3].dmem_req = 1'b1; vin[3].dhit = 1'b1; vc[3] = C_RUN; vm[3] = 1'b1;
      vin[4] = idle(); vc[4] = C_RUN; vm[4] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(vin[i], 1'b1, vc[i], vm[i], C_RUN, 1'b0);
         e = sb_a.pop_front();
         g = obs_a();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL mem_wait cyc%0d: got %h expected %h", i, g, e);
         end
      end
   endtask

   task automatic test_branch();
      in_t  vin[7];
      ctl_t vc[7];
      logic vm[7];
      exp_t e, g;
      vin[0] = load_use();                                            vc[0] = C_HZ;  vm[0] = 1'b0;
      vin[1] = idle(); vin[1].branch_taken = 1'b1;                    vc[1] = C_FL;  vm[1] = 1'b0;
      vin[2] = idle();                                                vc[2] = C_RUN; vm[2] = 1'b0;
      vin[3] = load_use(); vin[3].branch_taken = 1'b1;                vc[3] = C_FL;  vm[3] = 1'b0;
      vin[4] = idle(); vin[4].branch_taken = 1'b1; vin[4].dmem_req = 1'b1;
                                                                      vc[4] = C_DW;  vm[4] = 1'b0;
      vin[5] = vin[4]; vin[5].dhit = 1'b1;                            vc[5] = C_FL;  vm[5] = 1'b1;
      vin[6] = idle();                                                vc[6] = C_RUN; vm[6] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         drive(vin[i], 1'b1, vc[i], vm[i], C_RUN, 1'b0);
         e = sb_a.pop_front();
         g = obs_a();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL branch cyc%0d: got %h expected %h", i, g, e);
         end
      end
   endtask

   task automatic test_saturation();
      in_t  vi, vc;
      exp_t e, g;
      vi = idle();
      vi.ihit = 1'b0;
      for (int i = 0; i < 23; i++) begin
         vc = (i < 20) ? vi : idle();
         if (i == 20) begin
            vc = vi;
            vc.perf_clr = 1'b1;
         end
         drive(vc, 1'b1, (i <= 20) ? C_IW : C_RUN, 1'b0, C_RUN, 1'b0);
         e = sb_a.pop_front();
         g = obs_a();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL saturate cyc%0d: got %h expected %h", i, g, e);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      in_t  vin[3];
      ctl_t vc[3];
      logic vr[3];
      exp_t e, g;
      vin[0] = load_use(); vc[0] = C_HZ;  vr[0] = 1'b1;
      vin[1] = load_use(); vc[1] = C_RST; vr[1] = 1'b0;
      vin[2] = idle();     vc[2] = C_RUN; vr[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(vin[i], vr[i], vc[i], 1'b0, C_RUN, 1'b0);
         e = sb_a.pop_front();
         g = obs_a();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL reset_mid_stall cyc%0d: got %h expected %h", i, g, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_lu_extend();
      test_forward();
      test_stall_only();
      test_mem_wait();
      test_branch();
      test_saturation();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised pipeline hazard controller for the five-stage CPU, sitting beside the datapath latches. It generates per-latch control, the PC write enable and EX-stage operand forwarding selects. Its stall/flush state machine supports configurable load-use penalty, stall-only or forwarding mode and taken-branch flush. It also keeps saturating stall and flush performance counters.

## Interface
- FORWARD_EN, 1, 1 = EX operand forwarding plus load-use stall; 0 = stall on any RAW against EX or MEM.
- LU_STALL, 1, load-use stall cycles (1..7), used only when FORWARD_EN=1.
- REG_AW, 5, register address width.
- CNT_W, 16, width of each performance counter.
- CLK  in  1  clock; one clock domain.
- nRST  in  1  reset, synchronous, active-low.
- ihit, dhit  in  1  instruction/data memory done this cycle.
- dmem_req  in  1  MEM-stage instruction is a load or store.
- rs, rt  in  REG_AW  decode-stage sources.
- ex_rs, ex_rt  in  REG_AW  EX-stage sources, used for forwarding.
- ex_wsel, mem_wsel, wb_wsel  in  REG_AW  destinations.
- ex_wen, mem_wen, wb_wen  in  1  destination valid.
- ex_memread  in  1  EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch or jump.
- perf_clr  in  1  clear both counters.
- pc_wen  out  1  PC write enable.
- fd_state, de_state, em_state, mw_state  out  pipe_state_t  latch control: PIPE_ENABLE, PIPE_STALL or PIPE_NOP.
- fwd_a, fwd_b  out  fwd_t  EX operand select for ex_rs and ex_rt.
- mem_wait  out  1  registered; high in DWAIT.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- A register match requires the register to be nonzero, its wen to be 1, and the addresses to be equal.
- The first matching priority rule sets the outputs each cycle (pc_wen, fd/de/em/mw):
- P0 nRST=0: 0, NOP/NOP/NOP/NOP; fwd = FWD_RF.
- P1 dmem_req & !dhit: 0, STALL/STALL/STALL/NOP.
- P2 !ihit: 0, STALL/STALL/NOP/ENABLE.
- P3 branch_taken: 1, NOP/NOP/ENABLE/ENABLE.
- P4 hazard: 0, STALL/NOP/ENABLE/ENABLE.
  - FORWARD_EN=1: the hazard is (state LUSTALL) or (ex_memread & ex_wsel matches rs or rt).
  - FORWARD_EN=0: the hazard is ex_wsel or mem_wsel matching rs or rt.
- P5 otherwise: 1, all ENABLE.
- Forwarding (FORWARD_EN=1, combinational):
  - fwd_a = FWD_MEM if mem_wsel matches ex_rs.
  - Otherwise fwd_a = FWD_WB if wb_wsel matches ex_rs.
  - Otherwise fwd_a = FWD_RF.
  - fwd_b is the same against ex_rt.
  - FORWARD_EN=0: both are tied to FWD_RF.
- FSM states are RUN, LUSTALL and DWAIT, plus a 3-bit lu_cnt.
  - RUN, P1 → DWAIT.
  - RUN, P4 load-use with LU_STALL>1 → LUSTALL, lu_cnt = LU_STALL-1.
  - LUSTALL: lu_cnt decrements only on cycles where P4 applies. At lu_cnt=1 with P4 it goes → RUN.
  - LUSTALL, P3 → RUN with lu_cnt cleared. The older branch wins.
  - LUSTALL, P1 → DWAIT with lu_cnt frozen.
  - DWAIT leaves when P1 no longer applies: to LUSTALL if lu_cnt≠0, else to RUN.
- Counters (CNT_W, saturating at all-ones):
  - stall_cnt increments when nRST=1 and pc_wen=0.
  - flush_cnt increments on P3.
  - perf_clr has priority over increment.

## Timing
- Latch controls, pc_wen and fwd_* are combinational from inputs and registered state: zero-cycle latency.
- State, lu_cnt, mem_wait and the counters update on the CLK rising edge.
- Reset values: state RUN, lu_cnt 0, mem_wait 0, stall_cnt 0, flush_cnt 0.
- Reset mid-stall: the next edge returns the block to RUN; no stall persists past reset.
- A load-use stall with FORWARD_EN=1 lasts exactly LU_STALL cycles in which ihit=1. P1 and P2 cycles extend it without consuming the count.
- Simultaneous branch_taken and a hazard: the flush wins and no stall cycle is counted.
- Simultaneous P1 and P3: P1 wins, and the branch is re-presented when released.

## Structure
- cpu_types_pkg gains fwd_t (2-bit: FWD_RF=0, FWD_MEM=1, FWD_WB=2) and hu_state_t (RUN, LUSTALL, DWAIT).
- pipe_state_t is reused unchanged.
- hazard_unit_if is extended with the new signals.
- Sub-module sat_counter (parameter W; ports clr, inc, cnt) is instantiated twice.

## Test plan
- Reset: hold nRST=0 with ihit=1 → all latches NOP, pc_wen=0. Release → RUN, counters 0, all ENABLE.
- Load-use: FORWARD_EN=1, LU_STALL=2, ex_memread=1, ex_wsel=8, rs=8 → two cycles of fd STALL/de NOP, stall_cnt=2, then ENABLE. rs=0 in the same setup → no stall.
- Forward priority: mem_wsel=wb_wsel=ex_rs=3, both wen → fwd_a=FWD_MEM. Drop mem_wen → FWD_WB. FORWARD_EN=0 build → FWD_RF and a stall on ex_wsel=rt.
- Memory wait: dmem_req=1, dhit=0 for 3 cycles → mem_wait high for 3 cycles, mw NOP, stall_cnt=3. dhit=1 → all ENABLE.
- Branch during LUSTALL: branch_taken=1 in cycle 2 → fd/de NOP, pc_wen=1, state RUN, flush_cnt=1.
- Saturation/clear: CNT_W=4, 20 stall cycles → stall_cnt=15. perf_clr in a stall cycle → 0 next edge.
